// File: rtl/arch_reg_file_ckpt_if.sv
// Bus bundle for the architectural register file: retire writes, read ports and the flush-recovery stream.
interface arch_reg_file_ckpt_if #(
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RETIRE_WIDTH = 4,
  parameter int unsigned READ_PORTS   = 2,
  parameter int unsigned COPY_WIDTH   = 4
);
  localparam int unsigned IW = $clog2(NUM_AREGS);

  logic [RETIRE_WIDTH-1:0]      retire_valid;
  logic [RETIRE_WIDTH*IW-1:0]   retire_idx;
  logic [RETIRE_WIDTH*XLEN-1:0] retire_data;
  logic [READ_PORTS*IW-1:0]     rd_idx;
  logic [READ_PORTS*XLEN-1:0]   rd_data;
  logic                         flush_req;
  logic                         flush_busy;
  logic                         cp_valid;
  logic                         cp_ready;
  logic [IW-1:0]                cp_idx;
  logic [COPY_WIDTH*XLEN-1:0]   cp_data;
  logic                         cp_last;
  logic                         flush_done;

  modport master (
    output retire_valid, retire_idx, retire_data, rd_idx, flush_req, cp_ready,
    input  rd_data, flush_busy, cp_valid, cp_idx, cp_data, cp_last, flush_done
  );

  modport slave (
    input  retire_valid, retire_idx, retire_data, rd_idx, flush_req, cp_ready,
    output rd_data, flush_busy, cp_valid, cp_idx, cp_data, cp_last, flush_done
  );
endinterface

// File: rtl/arch_reg_file_ckpt.sv
// Architectural register file written at retire, with same-cycle read bypass and a
// flush-recovery engine that streams the committed state COPY_WIDTH registers per beat.
module arch_reg_file_ckpt #(
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RETIRE_WIDTH = 4,
  parameter int unsigned READ_PORTS   = 2,
  parameter int unsigned COPY_WIDTH   = 4,
  parameter bit          ZERO_REG     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  arch_reg_file_ckpt_if.slave  bus
);
  localparam int unsigned IW = $clog2(NUM_AREGS);
  localparam logic [IW-1:0] LAST_PTR = IW'(NUM_AREGS - COPY_WIDTH);
  localparam logic [IW-1:0] PTR_STEP = IW'(COPY_WIDTH);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [XLEN-1:0] regs [NUM_AREGS];
  logic [RETIRE_WIDTH-1:0] wr_slot;
  logic            wr_en;
  logic [XLEN-1:0] rd_val;
  logic [READ_PORTS*XLEN-1:0] rd_flat;
  logic [COPY_WIDTH*XLEN-1:0] cp_flat;

  // Array is frozen while streaming so a stalled beat keeps its data.
  assign wr_en = (state_q != STREAM);

  always_comb begin
    wr_slot = '0;
    for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
      wr_slot[s] = wr_en && bus.retire_valid[s] &&
                   !(ZERO_REG && (bus.retire_idx[s*IW +: IW] == '0));
    end
  end

  // Later slots are younger; the last non-blocking write in the loop wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_AREGS; i++) regs[i] <= '0;
    end else begin
      for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
        if (wr_slot[s]) regs[bus.retire_idx[s*IW +: IW]] <= bus.retire_data[s*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    rd_val  = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_val = regs[bus.rd_idx[p*IW +: IW]];
      for (int unsigned s = 0; s < RETIRE_WIDTH; s++) begin
        if (wr_slot[s] && (bus.retire_idx[s*IW +: IW] == bus.rd_idx[p*IW +: IW]))
          rd_val = bus.retire_data[s*XLEN +: XLEN];
      end
      if (ZERO_REG && (bus.rd_idx[p*IW +: IW] == '0)) rd_val = '0;
      rd_flat[p*XLEN +: XLEN] = rd_val;
    end
  end

  assign bus.rd_data = rd_flat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.flush_req) begin
          state_d = STREAM;
          ptr_d   = '0;
        end
      end
      STREAM: begin
        if (bus.cp_ready) begin
          if (ptr_q == LAST_PTR) state_d = DONE;
          else                   ptr_d   = ptr_q + PTR_STEP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat payload reads the frozen array directly, no retire bypass.
  always_comb begin
    cp_flat = '0;
    for (int unsigned j = 0; j < COPY_WIDTH; j++) begin
      cp_flat[j*XLEN +: XLEN] = regs[ptr_q + IW'(j)];
    end
  end

  assign bus.cp_data    = cp_flat;
  assign bus.cp_idx     = ptr_q;
  assign bus.cp_valid   = (state_q == STREAM);
  assign bus.flush_busy = (state_q == STREAM);
  assign bus.cp_last    = (state_q == STREAM) && (ptr_q == LAST_PTR);
  assign bus.flush_done = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (!rst && (state_q == STREAM)) begin
      assert (bus.retire_valid == '0)
        else $error("retire_valid asserted during recovery stream");
    end
  end
endmodule

// File: tb/tb_arch_reg_file_ckpt.sv
// Self-checking bench for arch_reg_file_ckpt: directed and random retire/read traffic plus
// recovery streams, compared against an array model of the architectural state.
module tb_arch_reg_file_ckpt;
  localparam int unsigned N  = 32;
  localparam int unsigned XL = 32;
  localparam int unsigned RW = 4;
  localparam int unsigned RP = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned IW = 5;
  localparam int unsigned BEATS = N / CW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [XL-1:0] mref [N];

  arch_reg_file_ckpt_if #(.NUM_AREGS(N), .XLEN(XL), .RETIRE_WIDTH(RW),
                          .READ_PORTS(RP), .COPY_WIDTH(CW)) bus ();

  arch_reg_file_ckpt #(.NUM_AREGS(N), .XLEN(XL), .RETIRE_WIDTH(RW), .READ_PORTS(RP),
                       .COPY_WIDTH(CW), .ZERO_REG(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_retire();
    bus.retire_valid = '0;
    bus.retire_idx   = '0;
    bus.retire_data  = '0;
  endtask

  task automatic set_slot(input int s, input logic [IW-1:0] idx, input logic [XL-1:0] data);
    bus.retire_valid[s]           = 1'b1;
    bus.retire_idx[s*IW +: IW]    = idx;
    bus.retire_data[s*XL +: XL]   = data;
  endtask

  task automatic set_reads(input logic [IW-1:0] a, input logic [IW-1:0] b);
    bus.rd_idx = {b, a};
  endtask

  // Architectural view: x0 is zero, otherwise youngest pending retire, else committed value.
  function automatic logic [XL-1:0] exp_read(input logic [IW-1:0] ri);
    logic [XL-1:0] v;
    if (ri == '0) return '0;
    v = mref[ri];
    for (int s = 0; s < RW; s++)
      if (bus.retire_valid[s] && bus.retire_idx[s*IW +: IW] == ri) v = bus.retire_data[s*XL +: XL];
    return v;
  endfunction

  task automatic commit_model();
    for (int s = 0; s < RW; s++)
      if (bus.retire_valid[s] && bus.retire_idx[s*IW +: IW] != '0)
        mref[bus.retire_idx[s*IW +: IW]] = bus.retire_data[s*XL +: XL];
  endtask

  function automatic logic [127:0] exp_beat(input int k);
    logic [127:0] r = '0;
    for (int j = 0; j < CW; j++) r[j*XL +: XL] = mref[k*CW + j];
    return r;
  endfunction

  task automatic check_reads(input string tag);
    check({tag, "_p0"}, 128'(bus.rd_data[0 +: XL]), 128'(exp_read(bus.rd_idx[0 +: IW])));
    check({tag, "_p1"}, 128'(bus.rd_data[XL +: XL]), 128'(exp_read(bus.rd_idx[IW +: IW])));
  endtask

  // Runs one stream already launched; mode 0 always ready, mode 1 ready pattern 1,0,0.
  task automatic run_stream(input int mode, input int pulse_at, input string tag);
    int k = 0;
    int done_seen = 0;
    int done_cyc = -1;
    for (int c = 0; c < 60; c++) begin
      bus.cp_ready  = (mode == 0) ? 1'b1 : ((c % 3) == 0);
      bus.flush_req = (c == pulse_at);
      #1;
      if (bus.cp_valid) begin
        check({tag, "_busy"}, 128'(bus.flush_busy), 128'(1));
        check({tag, "_idx"},  128'(bus.cp_idx), 128'(k * CW));
        check({tag, "_data"}, bus.cp_data, exp_beat(k));
        check({tag, "_last"}, 128'(bus.cp_last), 128'(k == BEATS - 1));
        check({tag, "_nodone"}, 128'(bus.flush_done), 128'(0));
        if (bus.cp_ready) k++;
      end else if (bus.flush_done) begin
        done_seen++;
        done_cyc = c;
        check({tag, "_done_busy"}, 128'(bus.flush_busy), 128'(0));
      end
      tick();
      if (done_seen != 0) break;
    end
    bus.flush_req = 1'b0;
    #1;
    check({tag, "_beats"}, 128'(k), 128'(BEATS));
    check({tag, "_done_cnt"}, 128'(done_seen), 128'(1));
    if (mode == 0) check({tag, "_done_cycle"}, 128'(done_cyc), 128'(BEATS));
    check({tag, "_idle_valid"}, 128'(bus.cp_valid), 128'(0));
    check({tag, "_idle_done"}, 128'(bus.flush_done), 128'(0));
  endtask

  initial begin
    clear_retire();
    bus.rd_idx    = '0;
    bus.flush_req = 1'b0;
    bus.cp_ready  = 1'b0;
    for (int i = 0; i < N; i++) mref[i] = '0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_reads(IW'(i), IW'(N - 1 - i));
      #1;
      check("reset_read", 128'(bus.rd_data), 128'(0));
    end
    check("reset_busy",  128'(bus.flush_busy), 128'(0));
    check("reset_valid", 128'(bus.cp_valid), 128'(0));
    check("reset_last",  128'(bus.cp_last), 128'(0));
    check("reset_done",  128'(bus.flush_done), 128'(0));

    // Four slots, four registers, bypass on x6
    set_slot(0, 5'd5, 32'hA); set_slot(1, 5'd6, 32'hB);
    set_slot(2, 5'd7, 32'hC); set_slot(3, 5'd8, 32'hD);
    set_reads(5'd6, 5'd8);
    #1;
    check("bypass_x6", 128'(bus.rd_data[0 +: XL]), 128'(32'hB));
    check_reads("bypass4");
    commit_model();
    tick();
    clear_retire();
    for (int i = 5; i <= 8; i++) begin
      set_reads(IW'(i), IW'(i));
      #1;
      check("stored_x5_8", 128'(bus.rd_data[0 +: XL]), 128'(32'hA + i - 5));
    end

    // Same-index collision: youngest slot wins; x0 write dropped
    set_slot(0, 5'd9, 32'h1); set_slot(3, 5'd9, 32'h2); set_slot(1, 5'd0, 32'hFFFF);
    set_reads(5'd9, 5'd0);
    #1;
    check("collide_bypass", 128'(bus.rd_data[0 +: XL]), 128'(32'h2));
    check("x0_bypass", 128'(bus.rd_data[XL +: XL]), 128'(0));
    commit_model();
    tick();
    clear_retire();
    #1;
    check("collide_stored", 128'(bus.rd_data[0 +: XL]), 128'(32'h2));
    check("x0_stored", 128'(bus.rd_data[XL +: XL]), 128'(0));

    // Random retire/read traffic
    for (int c = 0; c < 60; c++) begin
      clear_retire();
      for (int s = 0; s < RW; s++)
        if ($urandom_range(1, 0) != 0) set_slot(s, IW'($urandom_range(N - 1, 0)), $urandom);
      if ((c % 4) == 0 && bus.retire_valid[0])
        set_reads(bus.retire_idx[0 +: IW], IW'($urandom_range(N - 1, 0)));
      else
        set_reads(IW'($urandom_range(N - 1, 0)), IW'($urandom_range(N - 1, 0)));
      #1;
      check_reads("rand");
      commit_model();
      tick();
    end
    clear_retire();

    // Preload x(i) = i + 0x100
    for (int b = 0; b < BEATS; b++) begin
      for (int s = 0; s < RW; s++) set_slot(s, IW'(b * RW + s), 32'h100 + b * RW + s);
      commit_model();
      tick();
    end
    clear_retire();

    // Flush with free-running ready; retire in the flush_req cycle is included
    set_slot(2, 5'd3, 32'h333);
    bus.flush_req = 1'b1;
    commit_model();
    tick();
    clear_retire();
    bus.flush_req = 1'b0;
    run_stream(0, -1, "stream_ready");
    for (int i = 0; i < N; i++) begin
      set_reads(IW'(i), IW'(i));
      #1;
      check("post_stream_read", 128'(bus.rd_data[XL +: XL]), 128'(exp_read(IW'(i))));
    end

    // Backpressured stream with an ignored mid-stream flush_req
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    run_stream(1, 4, "stream_bp");
    tick();
    check("no_restart_valid", 128'(bus.cp_valid), 128'(0));

    // Reset during beat 3
    bus.flush_req = 1'b1;
    bus.cp_ready  = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_idx", 128'(bus.cp_idx), 128'(12));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) mref[i] = '0;
    #1;
    check("rst_mid_valid", 128'(bus.cp_valid), 128'(0));
    check("rst_mid_busy",  128'(bus.flush_busy), 128'(0));
    check("rst_mid_done",  128'(bus.flush_done), 128'(0));
    for (int i = 0; i < N; i++) begin
      set_reads(IW'(i), IW'(N - 1 - i));
      #1;
      check("rst_mid_read", 128'(bus.rd_data), 128'(0));
    end
    tick();
    check("rst_mid_done2", 128'(bus.flush_done), 128'(0));
    bus.flush_req = 1'b1;
    tick();
    bus.flush_req = 1'b0;
    run_stream(0, -1, "stream_zero");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
